// File: rtl/pdm_speaker_pkg.sv
// -----------------------------------------------------------------------------
// pkg_pdm_speaker
// Shared definitions for the PDM speaker peripheral:
//   - Wishbone controller/peripheral bundle types (iWishbone_Ctrl, iWishbone_Peri)
//   - register address map, STATUS/CTRL bit positions
//   - midscale helper (2^(W-1), the "silence" code of an offset-binary sample)
// -----------------------------------------------------------------------------
package pkg_pdm_speaker;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    // Controller -> peripheral
    typedef struct packed {
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } iWishbone_Ctrl;

    // Peripheral -> controller
    typedef struct packed {
        logic             ack;
        logic [WB_DW-1:0] dat;
    } iWishbone_Peri;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_NONE   = 2'd3
    } reg_addr_e;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_UNDERRUN = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_LEVEL    = 8;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // Midscale code for a sample of the given width.
    function automatic logic [WB_DW-1:0] midscale(input int bits);
        return WB_DW'(1) << (bits - 1);
    endfunction

endpackage

// File: rtl/pdm_speaker_fifo.sv
// -----------------------------------------------------------------------------
// pdm_fifo
// Synchronous first-word-fall-through sample FIFO. The head entry is always
// visible on pop_data while not empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_data     write request and data
//   pop                 consume the head entry (ignored when empty)
//   pop_data            head entry
//   full, empty, level  occupancy status
// -----------------------------------------------------------------------------
module pdm_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign level   = level_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Fall-through head: small depth, read straight from the array.
    assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/pdm_speaker.sv
// -----------------------------------------------------------------------------
// pdm_speaker
// Wishbone-attached PCM-to-PDM converter for a class-D speaker amplifier.
// PCM samples written to DATA are queued in a FIFO and fed, one per pOsr PDM
// bits, to a first-order sigma-delta modulator clocked by a divided bit clock.
// Ports:
//   clk       system / Wishbone clock
//   rst_n     synchronous active-low reset
//   wb_p      Wishbone peripheral side (ack = stb, zero-wait; read data)
//   wb_c      Wishbone controller side (stb, we, adr, dat)
//   pdm_clk   PDM bit clock to the amplifier
//   pdm_data  PDM bitstream (updates on the pdm_clk falling toggle)
//   irq       level interrupt: enable & irq_en & FIFO at or below half full
// Register map (adr[1:0]): 0 DATA (wr), 1 STATUS (rd, W1C bits 2/3),
//   2 CTRL (bit0 enable, bit1 irq_en), 3 reserved (reads 0).
// Build option: define PDM_SPEAKER_SIGNED_EN for two's-complement samples
//   (MSB inverted on entry to the modulator); otherwise offset-binary.
// -----------------------------------------------------------------------------
module pdm_speaker
    import pkg_pdm_speaker::*;
#(
    parameter int pWbHz      = 0,
    parameter int pPdmHz     = 3000000,
    parameter int pAudioBits = 16,
    parameter int pOsr       = 64,
    parameter int pFifoDepth = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output iWishbone_Peri wb_p,
    input  iWishbone_Ctrl wb_c,
    output logic          pdm_clk,
    output logic          pdm_data,
    output logic          irq
);

    localparam int W       = pAudioBits;
    localparam int DIV_RAW = pWbHz / pPdmHz / 2;
    // A misconfigured ratio below 1 degrades to toggling every clock.
    localparam int DIV_T   = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV_T > 1) ? $clog2(DIV_T) : 1;
    localparam int BW      = (pOsr > 1) ? $clog2(pOsr) : 1;
    localparam int LW      = $clog2(pFifoDepth) + 1;

    localparam logic [W-1:0]  MID      = W'(midscale(W));
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_T - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(pOsr - 1);

`ifdef PDM_SPEAKER_SIGNED_EN
    // Two's complement -> offset binary: flipping the MSB maps 0 to midscale.
    localparam logic [W-1:0] SAMPLE_XOR = MID;
`else
    localparam logic [W-1:0] SAMPLE_XOR = '0;
`endif

    // ---------------------------------------------------------------- state
    logic          enable_reg;
    logic          irq_en_reg;
    logic          underrun_reg;
    logic          overflow_reg;
    logic [DW-1:0] div_reg;
    logic          pdm_clk_reg;
    logic          pdm_data_reg;
    logic [BW-1:0] bit_cnt_reg;
    logic [W-1:0]  acc_reg;
    logic [W-1:0]  sample_reg;

    // ---------------------------------------------------------------- bus
    logic [1:0]       sel;
    logic             bus_wr;
    logic             data_wr;
    logic             status_wr;
    logic             ctrl_wr;
    logic [WB_DW-1:0] rd_dat;
    logic             unused_bits;

    // ---------------------------------------------------------------- fifo
    logic          fifo_pop;
    logic [W-1:0]  fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    // ---------------------------------------------------------------- datapath
    logic          strobe;
    logic          wrap;
    logic          overflow_set;
    logic [W-1:0]  sample_conv;

    assign sel       = wb_c.adr[1:0];
    assign bus_wr    = wb_c.stb && wb_c.we;
    assign data_wr   = bus_wr && (sel == REG_DATA);
    assign status_wr = bus_wr && (sel == REG_STATUS);
    assign ctrl_wr   = bus_wr && (sel == REG_CTRL);

    // Only the low address bits and the low data bits are decoded.
    assign unused_bits = ^{wb_c.adr, wb_c.dat};

    // Strobe marks the 1->0 toggle of the bit clock; wrap is the last bit of
    // a sample period, where the next sample is fetched.
    assign strobe       = enable_reg && (div_reg == DIV_LAST) && pdm_clk_reg;
    assign wrap         = strobe && (bit_cnt_reg == BIT_LAST);
    assign fifo_pop     = wrap && !fifo_empty;
    assign overflow_set = data_wr && fifo_full && !fifo_pop;
    assign sample_conv  = fifo_dout ^ SAMPLE_XOR;

    pdm_fifo #(
        .W     (W),
        .DEPTH (pFifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (data_wr),
        .push_data (wb_c.dat[W-1:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Control and sticky status. A flag event in the same cycle as its
    // W1C clear wins, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_reg   <= 1'b0;
            irq_en_reg   <= 1'b0;
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_reg <= wb_c.dat[CTRL_ENABLE];
                irq_en_reg <= wb_c.dat[CTRL_IRQ_EN];
            end
            underrun_reg <= (underrun_reg & ~(status_wr & wb_c.dat[STAT_UNDERRUN]))
                          | (wrap & fifo_empty);
            overflow_reg <= (overflow_reg & ~(status_wr & wb_c.dat[STAT_OVERFLOW]))
                          | overflow_set;
        end
    end

    // Divider, bit counter and first-order modulator. While disabled every
    // counter is parked at 0 so re-enabling restarts from a known phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg      <= '0;
            pdm_clk_reg  <= 1'b0;
            pdm_data_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            acc_reg      <= '0;
            sample_reg   <= MID;
        end else if (!enable_reg) begin
            div_reg      <= '0;
            pdm_clk_reg  <= 1'b0;
            pdm_data_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            acc_reg      <= '0;
        end else begin
            if (div_reg == DIV_LAST) begin
                div_reg     <= '0;
                pdm_clk_reg <= ~pdm_clk_reg;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
            if (strobe) begin
                // Carry out of the accumulator is the output bit.
                {pdm_data_reg, acc_reg} <= {1'b0, acc_reg} + {1'b0, sample_reg};
                if (wrap) begin
                    bit_cnt_reg <= '0;
                    sample_reg  <= fifo_empty ? MID : sample_conv;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Register read mux.
    always_comb begin
        rd_dat = '0;
        case (reg_addr_e'(sel))
            REG_STATUS: begin
                rd_dat[STAT_EMPTY]        = fifo_empty;
                rd_dat[STAT_FULL]         = fifo_full;
                rd_dat[STAT_UNDERRUN]     = underrun_reg;
                rd_dat[STAT_OVERFLOW]     = overflow_reg;
                rd_dat[STAT_LEVEL +: LW]  = fifo_level;
            end
            REG_CTRL: begin
                rd_dat[CTRL_ENABLE] = enable_reg;
                rd_dat[CTRL_IRQ_EN] = irq_en_reg;
            end
            default: rd_dat = '0;
        endcase
    end

    assign wb_p.ack = wb_c.stb;
    assign wb_p.dat = rd_dat;

    assign pdm_clk  = pdm_clk_reg;
    assign pdm_data = pdm_data_reg;
    assign irq      = enable_reg && irq_en_reg && (fifo_level <= LW'(pFifoDepth / 2));

endmodule

// File: tb/tb_pdm_speaker.sv
// -----------------------------------------------------------------------------
// tb_pdm_speaker
// Self-checking bench for pdm_speaker at 12 MHz / 3 MHz (4-clock bit period),
// 16-bit samples, OSR 64, FIFO depth 16. A sample-level reference model
// (queue + integer accumulator + edge counter since enable) predicts pdm_clk,
// pdm_data, irq and STATUS/CTRL every cycle.
// -----------------------------------------------------------------------------
module tb_pdm_speaker;
    import pkg_pdm_speaker::*;

    localparam int WB_HZ = 12000000;
    localparam int PDM_HZ = 3000000;
    localparam int W     = 16;
    localparam int OSR   = 64;
    localparam int D     = 16;
    localparam int T     = WB_HZ / PDM_HZ / 2;
    localparam int unsigned MIDV = 32'h8000;

    logic          clk;
    logic          rst_n;
    iWishbone_Peri wb_p;
    iWishbone_Ctrl wb_c;
    logic          pdm_clk;
    logic          pdm_data;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    pdm_speaker #(
        .pWbHz      (WB_HZ),
        .pPdmHz     (PDM_HZ),
        .pAudioBits (W),
        .pOsr       (OSR),
        .pFifoDepth (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_p     (wb_p),
        .wb_c     (wb_c),
        .pdm_clk  (pdm_clk),
        .pdm_data (pdm_data),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ model state
    int          m_en, m_irq_en, m_und, m_ovf;
    int          m_ecnt, m_pclk, m_pdata, m_bit;
    int unsigned m_acc, m_s;
    int unsigned q[$];
    bit          m_strobe;

    function automatic int unsigned conv(input int unsigned x);
`ifdef PDM_SPEAKER_SIGNED_EN
        return x ^ MIDV;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] v;
        v = '0;
        v[0] = (q.size() == 0);
        v[1] = (q.size() == D);
        v[2] = m_und[0];
        v[3] = m_ovf[0];
        v[8 +: 5] = 5'(q.size());
        return v;
    endfunction

    function automatic logic [31:0] exp_ctrl();
        return 32'(m_en[0]) | (32'(m_irq_en[0]) << 1);
    endfunction

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_und = 0; m_ovf = 0;
        m_ecnt = 0; m_pclk = 0; m_pdata = 0; m_bit = 0;
        m_acc = 0; m_s = MIDV;
        q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model from the inputs being driven, then
    // compare the DUT's free-running outputs just after the edge.
    task automatic tick();
        bit wr, wrap, und_set, ovf_set;
        int unsigned sum;
        wr = wb_c.stb && wb_c.we;
        wrap = 0; und_set = 0; ovf_set = 0;
        m_strobe = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_en != 0) begin
                m_ecnt++;
                m_pclk   = (m_ecnt / T) % 2;
                m_strobe = (m_ecnt % (2 * T)) == 0;
            end else begin
                m_ecnt = 0; m_pclk = 0; m_pdata = 0; m_acc = 0; m_bit = 0;
            end
            if (m_strobe) begin
                sum     = m_acc + m_s;
                m_pdata = int'(sum >> W);
                m_acc   = sum % (32'd1 << W);
                m_bit++;
                if (m_bit == OSR) begin
                    m_bit = 0;
                    wrap  = 1;
                end
            end
            if (wrap) begin
                if (q.size() > 0) m_s = conv(q.pop_front());
                else begin m_s = MIDV; und_set = 1; end
            end
            if (wr && wb_c.adr[1:0] == 2'd0) begin
                if (q.size() < D) q.push_back(int'(wb_c.dat[W-1:0]));
                else ovf_set = 1;
            end
            if (wr && wb_c.adr[1:0] == 2'd1) begin
                if (wb_c.dat[2]) m_und = 0;
                if (wb_c.dat[3]) m_ovf = 0;
            end
            if (und_set) m_und = 1;
            if (ovf_set) m_ovf = 1;
            if (wr && wb_c.adr[1:0] == 2'd2) begin
                m_en     = int'(wb_c.dat[0]);
                m_irq_en = int'(wb_c.dat[1]);
            end
        end
        @(posedge clk);
        #1;
        chk("pdm_clk", 32'(pdm_clk), 32'(m_pclk));
        chk("pdm_data", 32'(pdm_data), 32'(m_pdata));
        chk("irq", 32'(irq), 32'((m_en != 0) && (m_irq_en != 0) && (q.size() <= D / 2)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        wb_c.stb = 1'b1; wb_c.we = 1'b1; wb_c.adr = 32'(a); wb_c.dat = d;
        $display("WR adr=%0d dat=0x%08h", a, d);
        tick();
        wb_c.stb = 1'b0; wb_c.we = 1'b0; wb_c.dat = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        wb_c.stb = 1'b1; wb_c.we = 1'b0; wb_c.adr = 32'(a); wb_c.dat = '0;
        #1;
        chk({tag, "_ack"}, 32'(wb_p.ack), 32'd1);
        chk(tag, wb_p.dat, exp);
        $display("RD adr=%0d dat=0x%08h exp=0x%08h", a, wb_p.dat, exp);
        tick();
        wb_c.stb = 1'b0;
    endtask

    initial begin
        int ones, highs, nstrobe, prev_irq;
        bit reached;

        wb_c  = '0;
        rst_n = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        bus_read(2'd1, exp_status(), "rst_status");
        bus_read(2'd2, exp_ctrl(), "rst_ctrl");
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, 32'd0, "rsvd_read");
        bus_read(2'd2, exp_ctrl(), "ctrl_after_rsvd");

        // Overflow with enable=0: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'($urandom_range(0, 65535)));
        bus_read(2'd1, exp_status(), "ovf_status");
        chk("ovf_status_abs", exp_status(), 32'h0000_100A);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, exp_status(), "ovf_cleared");

        // Play out a few random samples
        bus_write(2'd2, 32'h1);
        idle(3 * OSR * 2 * T + 20);
        bus_read(2'd1, exp_status(), "play_status");

        // Reset mid-stream
        rst_n = 1'b0;
        tick();
        chk("midrst_pdm_clk", 32'(pdm_clk), 32'd0);
        chk("midrst_pdm_data", 32'(pdm_data), 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        tick();
        bus_read(2'd1, exp_status(), "midrst_status");

        // Underrun from empty FIFO: 64 strobes at midscale -> 50% density
        bus_write(2'd2, 32'h1);
        ones = 0; highs = 0; nstrobe = 0;
        for (int i = 0; i < OSR * 2 * T + 4; i++) begin
            tick();
            if (i < 40) highs += int'(pdm_clk);
            if (m_strobe && nstrobe < OSR) begin
                ones += int'(pdm_data);
                nstrobe++;
            end
        end
        chk("clk_duty_highs_40", 32'(highs), 32'd20);
        chk("midscale_ones_64", 32'(ones), 32'd32);
        bus_read(2'd1, exp_status(), "underrun_status");
        chk("underrun_flag", 32'(m_und), 32'd1);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, exp_status(), "underrun_cleared");

        // Directed pattern samples
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        bus_write(2'd0, 32'h8000);
        bus_write(2'd0, 32'h8000);
        bus_write(2'd0, 32'h0000);
        bus_write(2'd0, 32'h7FFF);
        bus_write(2'd2, 32'h1);
        idle(5 * OSR * 2 * T + 8);
        bus_read(2'd1, exp_status(), "pattern_status");

        // irq on draining 9 -> 8
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'($urandom_range(0, 65535)));
        bus_write(2'd2, 32'h3);
        reached  = 0;
        prev_irq = int'(irq);
        for (int i = 0; i < OSR * 2 * T + 20 && !reached; i++) begin
            prev_irq = int'(irq);
            tick();
            if (q.size() == 8) reached = 1;
        end
        chk("irq_drain_reached", 32'(reached), 32'd1);
        chk("irq_before_pop", 32'(prev_irq), 32'd0);
        chk("irq_after_pop", 32'(irq), 32'd1);

        // Random mix of pushes, reads and idle time
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: bus_write(2'd0, 32'($urandom_range(0, 65535)));
                1: bus_read(2'd1, exp_status(), "rand_status");
                default: idle(int'($urandom_range(1, 60)));
            endcase
        end

        // Disable / re-enable restarts the divider from 0
        bus_write(2'd2, 32'h0);
        idle(5);
        bus_read(2'd2, exp_ctrl(), "ctrl_disabled");
        bus_write(2'd2, 32'h3);
        idle(2 * OSR * 2 * T);
        bus_read(2'd1, exp_status(), "final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_speaker.md
PDM_SPEAKER -- requirements
Module: pdm_speaker

Interface
REQ-001 SHALL have parameter pWbHz, default 0: system clock frequency in Hz; pWbHz/pPdmHz/2 SHALL be >= 1.
REQ-002 SHALL have parameter pPdmHz, default 3000000: PDM bit clock frequency in Hz.
REQ-003 SHALL have parameter pAudioBits, default 16: PCM sample width W.
REQ-004 SHALL have parameter pOsr, default 64: PDM bits per PCM sample; power of two.
REQ-005 SHALL have parameter pFifoDepth, default 16: sample FIFO depth; power of two.
REQ-006 SHALL have port clk, input, 1: the single system and Wishbone clock.
REQ-007 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port wb_p, output, iWishbone_Peri: Wishbone peripheral side (ack, dat).
REQ-009 SHALL have port wb_c, input, iWishbone_Ctrl: Wishbone controller side (stb, we, adr, dat).
REQ-010 SHALL have port pdm_clk, output, 1: PDM bit clock to the amplifier.
REQ-011 SHALL have port pdm_data, output, 1: PDM bitstream.
REQ-012 SHALL have port irq, output, 1: level interrupt for FIFO low water.

Function
REQ-013 SHALL drive wb_p.ack combinationally equal to wb_c.stb: zero-wait single-cycle access.
REQ-014 SHALL decode wb_c.adr[1:0] as follows: 0 = DATA (write pushes sample[W-1:0]); 1 = STATUS; 2 = CTRL (bit0 enable, bit1 irq_en, R/W); 3 = reads 0, writes ignored.
REQ-015 SHALL define STATUS as: bit0 empty, bit1 full, bit2 underrun (sticky), bit3 overflow (sticky), bits[8+:$clog2(pFifoDepth)+1] FIFO level.
REQ-016 SHALL clear STATUS bits 2 and 3 on a STATUS write where the corresponding data bit is 1 (write-1-to-clear).
REQ-017 SHALL drive wb_p.dat combinationally from the addressed register, with unused bits 0.
REQ-018 SHALL implement the divider as T = pWbHz/pPdmHz/2; counter runs 0..T-1; at T-1 it wraps to 0 and pdm_clk toggles.
REQ-019 SHALL define the bit strobe as the cycle in which pdm_clk toggles 1->0; pdm_data and the modulator SHALL update only on the bit strobe.
REQ-020 SHALL implement a first-order modulator on each strobe: {carry, acc} <= acc + s, with acc W bits, s the current sample, and pdm_data <= carry.
REQ-021 SHALL keep a bit counter 0..pOsr-1 that advances on each strobe; on wrap it SHALL pop the next FIFO sample into s, taking effect on the next strobe.
REQ-022 SHALL, on wrap with the FIFO empty, load s = 2^(W-1) (midscale) and set underrun.
REQ-023 SHALL accept a DATA write when the FIFO is not full or a pop occurs in the same cycle; otherwise it SHALL drop the data and set overflow.
REQ-024 SHALL, when enable=0, hold pdm_clk=0, pdm_data=0, divider, bit counter and acc at 0, perform no pops, and keep the FIFO writable.
REQ-025 SHALL drive irq = enable & irq_en & (level <= pFifoDepth/2).
REQ-026 SHALL, when enable goes 0->1, start with the divider at 0 and the first pop at the first bit-counter wrap.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, set pdm_clk=0, pdm_data=0, irq=0, FIFO empty, CTRL=0, sticky flags 0, counters 0, acc 0 and s=2^(W-1); this applies mid-operation as well.

Configuration
REQ-028 SHALL, with PDM_SPEAKER_SIGNED_EN defined, treat samples as two's complement and invert the sample MSB before it enters s; the underrun value remains 2^(W-1) after conversion, i.e. signed 0.
REQ-029 SHALL, without PDM_SPEAKER_SIGNED_EN, treat samples as unsigned offset-binary and pass them unchanged.

Structure
REQ-030 SHALL place register address constants, STATUS/CTRL bit positions and the midscale constant in shared package pkg_pdm_speaker.
REQ-031 SHALL implement the FIFO as sub-module pdm_fifo: synchronous, first-word-fall-through, with push/pop/full/empty/level outputs.

Verification
REQ-032 SHALL cover: pWbHz=12000000, pPdmHz=3000000, enable=1 -> pdm_clk period of 4 clk cycles, 50% duty.
REQ-033 SHALL cover: unsigned, push 0x8000 x2 -> during the second sample, pdm_data alternates 0,1,0,1 on each strobe; push 0x0000 -> all 0.
REQ-034 SHALL cover: push 17 samples with pFifoDepth=16 and enable=0 -> STATUS full=1, overflow=1, level=16; write STATUS 0x8 -> overflow=0.
REQ-035 SHALL cover: enable=1 with FIFO empty -> underrun=1 after 64 strobes and the pdm_data density is 50%.
REQ-036 SHALL cover: irq_en=1 with level draining 9->8 -> irq rises in the same cycle as the pop; rst_n=0 mid-stream -> all outputs 0 on the next clk.
REQ-037 SHALL cover: with PDM_SPEAKER_SIGNED_EN, push 0x0000 -> 0,1,0,1 pattern; push 0x7FFF -> pdm_data mostly 1.
